// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard control: bypass select, load-use and scoreboard stall, redirect flush.
// Optional HAZARD_PERF_CNT_EN adds stall/redirect cycle counters on perf_*_o.
module hazard_scoreboard_unit #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [AW-1:0]                     ra1_d_i,
    input  logic [AW-1:0]                     ra2_d_i,
    input  logic                              rs1_use_d_i,
    input  logic                              rs2_use_d_i,
    input  logic [AW-1:0]                     wa_d_i,
    input  logic                              long_d_i,
    input  logic                              issue_fire_i,
    input  logic [AW-1:0]                     wa_e_i,
    input  logic                              we_e_i,
    input  logic [AW-1:0]                     wa_m_i,
    input  logic                              we_m_i,
    input  logic [AW-1:0]                     wa_w_i,
    input  logic                              we_w_i,
    input  logic                              ld_e_i,
    input  logic                              cpl_valid_i,
    input  logic [AW-1:0]                     cpl_addr_i,
    input  logic                              redirect_i,
    output logic [1:0]                        sel_ra1_o,
    output logic [1:0]                        sel_ra2_o,
    output logic                              stall_d_o,
    output logic                              flush_f_o,
    output logic                              flush_d_o,
    output logic [NREG-1:0]                   busy_o,
    output logic [$clog2(MAX_OUT+1)-1:0]      out_cnt_o,
    output logic                              sb_err_o,
    output logic [31:0]                       perf_stall_o,
    output logic [31:0]                       perf_flush_o
);

    localparam int unsigned CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic            w_ld_u;
    logic            w_sb_u;
    logic            w_stall;
    logic            w_set_req;
    logic            w_cnt_full;
    logic            w_set;
    logic            w_clr;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    // Youngest producer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] ra,
        input logic          we_e, input logic [AW-1:0] wa_e,
        input logic          we_m, input logic [AW-1:0] wa_m,
        input logic          we_w, input logic [AW-1:0] wa_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != '0) begin
            if (we_e && (wa_e == ra))      sel = 2'b01;
            else if (we_m && (wa_m == ra)) sel = 2'b10;
            else if (we_w && (wa_w == ra)) sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        sel_ra1_o = fwd_sel(ra1_d_i, we_e_i, wa_e_i, we_m_i, wa_m_i, we_w_i, wa_w_i);
        sel_ra2_o = fwd_sel(ra2_d_i, we_e_i, wa_e_i, we_m_i, wa_m_i, we_w_i, wa_w_i);
    end

    // Stall sees registered busy only, so a completing register unblocks one cycle later.
    // The decode destination is treated as written; x0 is never busy so it cannot WAW-stall.
    always_comb begin
        w_ld_u = ld_e_i && we_e_i && (wa_e_i != '0) &&
                 ((rs1_use_d_i && (ra1_d_i == wa_e_i)) || (rs2_use_d_i && (ra2_d_i == wa_e_i)));
        w_cnt_full = (r_cnt == CNT_MAX);
        w_sb_u = (rs1_use_d_i && r_busy[ra1_d_i]) || (rs2_use_d_i && r_busy[ra2_d_i]) ||
                 r_busy[wa_d_i] || (long_d_i && w_cnt_full);
        w_stall = (w_ld_u || w_sb_u) && !redirect_i;
    end

    assign stall_d_o = w_stall;
    assign flush_f_o = redirect_i;
    assign flush_d_o = redirect_i;

    // Set wins over a same-register clear: the clear belongs to the older op.
    always_comb begin
        w_set_req  = issue_fire_i && long_d_i && (wa_d_i != '0) && !redirect_i;
        w_set      = w_set_req && !w_cnt_full;
        w_clr      = cpl_valid_i && r_busy[cpl_addr_i];
        w_set_vec  = w_set ? (NREG'(1) << wa_d_i) : '0;
        w_clr_vec  = w_clr ? (NREG'(1) << cpl_addr_i) : '0;
        w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;
        w_cnt_nxt  = r_cnt;
        if (w_set && !w_clr)                     w_cnt_nxt = r_cnt + CW'(1);
        else if (!w_set && w_clr && r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if ((w_set_req && w_cnt_full) || (cpl_valid_i && !r_busy[cpl_addr_i]))
                r_err <= 1'b1;
        end
    end

    assign busy_o    = r_busy;
    assign out_cnt_o = r_cnt;
    assign sb_err_o  = r_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall)    r_perf_stall <= r_perf_stall + 32'd1;
            if (redirect_i) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_o = r_perf_stall;
    assign perf_flush_o = r_perf_flush;
`else
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule
